// File: rtl/branch_predictor.sv
// Fetch-stage BTB plus 2-bit PHT with a combinational next-PC lookup and EX-stage training.
// Defining BP_GSHARE_EN adds a global history register that is XORed into the PHT index.
module branch_predictor #(
    parameter int IDX_W = 5,
    parameter int TAG_W = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [31:0] pred_next_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_branch,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0]             btb_valid;
    logic [DEPTH-1:0]             btb_jump;
    logic [DEPTH-1:0][TAG_W-1:0]  btb_tag;
    logic [DEPTH-1:0][31:0]       btb_target;
    logic [DEPTH-1:0][1:0]        pht;

    logic [IDX_W-1:0] look_idx;
    logic [IDX_W-1:0] look_pidx;
    logic [IDX_W-1:0] train_idx;
    logic [IDX_W-1:0] train_pidx;
    logic [TAG_W-1:0] look_tag;
    logic [TAG_W-1:0] train_tag;
    logic             hit;
    logic [1:0]       train_ctr;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;
`endif

    always_comb begin
        look_idx  = if_pc[IDX_W+1:2];
        train_idx = upd_pc[IDX_W+1:2];
        look_tag  = if_pc[31:IDX_W+2];
        train_tag = upd_pc[31:IDX_W+2];
`ifdef BP_GSHARE_EN
        look_pidx  = look_idx ^ ghr;
        train_pidx = train_idx ^ ghr;
`else
        look_pidx  = look_idx;
        train_pidx = train_idx;
`endif
        train_ctr    = pht[train_pidx];
        hit          = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
        pred_taken   = hit && (btb_jump[look_idx] || pht[look_pidx][1]);
        pred_target  = pred_taken ? btb_target[look_idx] : '0;
        pred_next_pc = pred_taken ? btb_target[look_idx] : if_pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid  <= '0;
            btb_jump   <= '0;
            btb_tag    <= '0;
            btb_target <= '0;
            pht        <= {DEPTH{2'b01}};
`ifdef BP_GSHARE_EN
            ghr        <= '0;
`endif
        end else if (upd_valid) begin
            // Only taken outcomes allocate; a not-taken branch leaves its BTB entry intact.
            if (upd_taken) begin
                btb_valid[train_idx]  <= 1'b1;
                btb_tag[train_idx]    <= train_tag;
                btb_target[train_idx] <= upd_target;
                btb_jump[train_idx]   <= !upd_is_branch;
            end
            if (upd_is_branch) begin
                if (upd_taken && train_ctr != 2'b11) begin
                    pht[train_pidx] <= train_ctr + 2'd1;
                end else if (!upd_taken && train_ctr != 2'b00) begin
                    pht[train_pidx] <= train_ctr - 2'd1;
                end
`ifdef BP_GSHARE_EN
                ghr <= {ghr[IDX_W-2:0], upd_taken};
`endif
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus a randomized run against a reference model.
module tb_branch_predictor;

    localparam int IDX_W = 5;
    localparam int TAG_W = 25;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] pred_next_pc;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_is_branch = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_pc        (if_pc),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .pred_next_pc (pred_next_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_is_branch(upd_is_branch),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target)
    );

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] next_pc;
    } pred_t;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ub;
        logic        ut;
        logic [31:0] utgt;
        logic        chk;
        logic        et;
        logic [31:0] etgt;
    } step_t;

    pred_t sb[$];
    step_t steps[$];
    int    errors = 0;
    int    checks = 0;

    function automatic step_t st(input logic rst, input logic [31:0] pc, input logic uv,
                                 input logic [31:0] upc, input logic ub, input logic ut,
                                 input logic [31:0] utgt, input logic chk, input logic et,
                                 input logic [31:0] etgt);
        step_t s;
        s.rst = rst; s.pc = pc; s.uv = uv; s.upc = upc; s.ub = ub; s.ut = ut;
        s.utgt = utgt; s.chk = chk; s.et = et; s.etgt = etgt;
        return s;
    endfunction

    function automatic pred_t expect_of(input step_t s);
        pred_t p;
        p.taken   = s.et;
        p.target  = s.et ? s.etgt : 32'h0;
        p.next_pc = s.et ? s.etgt : s.pc + 32'd4;
        return p;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic drive(input step_t s);
        @(posedge clk);
        #1;
        reset         = s.rst;
        if_pc         = s.pc;
        upd_valid     = s.uv;
        upd_pc        = s.upc;
        upd_is_branch = s.ub;
        upd_taken     = s.ut;
        upd_target    = s.utgt;
        if (s.chk) sb.push_back(expect_of(s));
    endtask

    task automatic test_reset();
        pred_t exp, got;
        steps.delete();
        steps.push_back(st(1, 32'h100, 1, 32'h100, 1, 1, 32'h80, 0, 0, 0));
        steps.push_back(st(0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0));
        steps.push_back(st(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            #2;
            if (steps[i].chk) begin
                exp = sb.pop_front();
                got = {pred_taken, pred_target, pred_next_pc};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL reset step %0d: got taken=%0b target=%h next=%h, expected taken=%0b target=%h next=%h",
                             i, got.taken, got.target, got.next_pc, exp.taken, exp.target, exp.next_pc);
                end
            end
        end
    endtask

    task automatic test_branch_train();
        pred_t exp, got;
        steps.delete();
        steps.push_back(st(0, 32'h100, 1, 32'h100, 1, 1, 32'h80, 1, 0, 0));
        steps.push_back(st(0, 32'h100, 1, 32'h100, 1, 0, 32'h0, 1, 1, 32'h80));
        steps.push_back(st(0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            #2;
            if (steps[i].chk) begin
                exp = sb.pop_front();
                got = {pred_taken, pred_target, pred_next_pc};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL branch_train step %0d: got taken=%0b target=%h next=%h, expected taken=%0b target=%h next=%h",
                             i, got.taken, got.target, got.next_pc, exp.taken, exp.target, exp.next_pc);
                end
            end
        end
    endtask

    // Counter starts at 01: 5T, 4N, 1T, lookup, 2T, lookup.
    task automatic test_saturation();
        pred_t exp, got;
        logic  ut_seq[12] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
        logic  et_seq[12] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
        steps.delete();
        for (int i = 0; i < 10; i++)
            steps.push_back(st(0, 32'h100, 1, 32'h100, 1, ut_seq[i], 32'h80, 1, et_seq[i], 32'h80));
        steps.push_back(st(0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 10; i < 12; i++)
            steps.push_back(st(0, 32'h100, 1, 32'h100, 1, ut_seq[i], 32'h80, 1, et_seq[i], 32'h80));
        steps.push_back(st(0, 32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h80));
        foreach (steps[i]) begin
            drive(steps[i]);
            #2;
            if (steps[i].chk) begin
                exp = sb.pop_front();
                got = {pred_taken, pred_target, pred_next_pc};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL saturation step %0d: got taken=%0b target=%h next=%h, expected taken=%0b target=%h next=%h",
                             i, got.taken, got.target, got.next_pc, exp.taken, exp.target, exp.next_pc);
                end
            end
        end
    endtask

    task automatic test_jump_alias();
        pred_t exp, got;
        steps.delete();
        steps.push_back(st(0, 32'h20, 1, 32'h20, 0, 1, 32'h200, 1, 0, 0));
        steps.push_back(st(0, 32'h20, 0, 0, 0, 0, 0, 1, 1, 32'h200));
        steps.push_back(st(0, 32'h180, 1, 32'h180, 0, 1, 32'h300, 1, 0, 0));
        steps.push_back(st(0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0));
        steps.push_back(st(0, 32'h180, 0, 0, 0, 0, 0, 1, 1, 32'h300));
        foreach (steps[i]) begin
            drive(steps[i]);
            #2;
            if (steps[i].chk) begin
                exp = sb.pop_front();
                got = {pred_taken, pred_target, pred_next_pc};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL jump_alias step %0d: got taken=%0b target=%h next=%h, expected taken=%0b target=%h next=%h",
                             i, got.taken, got.target, got.next_pc, exp.taken, exp.target, exp.next_pc);
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        pred_t exp, got;
        steps.delete();
        steps.push_back(st(0, 32'h40, 1, 32'h40, 1, 1, 32'h500, 1, 0, 0));
        steps.push_back(st(0, 32'h40, 0, 0, 0, 0, 0, 1, 1, 32'h500));
        steps.push_back(st(1, 32'h40, 0, 0, 0, 0, 0, 1, 1, 32'h500));
        steps.push_back(st(0, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0));
        steps.push_back(st(0, 32'h180, 0, 0, 0, 0, 0, 1, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            #2;
            if (steps[i].chk) begin
                exp = sb.pop_front();
                got = {pred_taken, pred_target, pred_next_pc};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL same_cycle step %0d: got taken=%0b target=%h next=%h, expected taken=%0b target=%h next=%h",
                             i, got.taken, got.target, got.next_pc, exp.taken, exp.target, exp.next_pc);
                end
            end
        end
    endtask

`ifdef BP_GSHARE_EN
    // Alternating T,N on one PC; the last four in-flight lookups and a final idle one must be correct.
    task automatic test_gshare();
        pred_t exp, got;
        logic  ut;
        steps.delete();
        steps.push_back(st(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 16; i++) begin
            ut = (i % 2) == 1;
            steps.push_back(st(0, 32'h100, 1, 32'h100, 1, ut, 32'h80, i >= 13, ut, 32'h80));
        end
        steps.push_back(st(0, 32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h80));
        foreach (steps[i]) begin
            drive(steps[i]);
            #2;
            if (steps[i].chk) begin
                exp = sb.pop_front();
                got = {pred_taken, pred_target, pred_next_pc};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL gshare step %0d: got taken=%0b target=%h next=%h, expected taken=%0b target=%h next=%h",
                             i, got.taken, got.target, got.next_pc, exp.taken, exp.target, exp.next_pc);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        pred_t       exp, got;
        step_t       s;
        logic        m_valid[32];
        logic        m_jump[32];
        logic [24:0] m_tag[32];
        logic [31:0] m_tgt[32];
        logic [1:0]  m_ctr[32];
        logic [4:0]  m_ghr;
        logic [4:0]  li, pi, ui, upi;
        logic        hit;
        logic [31:0] pool[8] = '{32'h100, 32'h180, 32'h20, 32'h40, 32'h1100, 32'h44, 32'hFFFF_FFFC, 32'h2040};
        for (int k = 0; k < 32; k++) begin
            m_valid[k] = 0; m_jump[k] = 0; m_tag[k] = '0; m_tgt[k] = '0; m_ctr[k] = 2'b01;
        end
        m_ghr = '0;
        drive(st(1, 32'h0, 1, 32'h100, 1, 1, 32'h80, 0, 0, 0));
        for (int n = 0; n < 300; n++) begin
            s.rst  = 0;
            s.pc   = pool[$urandom_range(0, 7)];
            s.uv   = $urandom_range(0, 2) != 0;
            s.upc  = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            s.ub   = $urandom_range(0, 3) != 0;
            s.ut   = s.ub ? 1'($urandom_range(0, 1)) : 1'b1;
            s.utgt = $urandom & 32'hFFFF_FFFC;
            li = s.pc[6:2];
`ifdef BP_GSHARE_EN
            pi = li ^ m_ghr;
`else
            pi = li;
`endif
            hit    = m_valid[li] && m_tag[li] == s.pc[31:7];
            s.chk  = 1;
            s.et   = hit && (m_jump[li] || m_ctr[pi][1]);
            s.etgt = m_tgt[li];
            drive(s);
            #2;
            exp = sb.pop_front();
            got = {pred_taken, pred_target, pred_next_pc};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random step %0d pc=%h: got taken=%0b target=%h next=%h, expected taken=%0b target=%h next=%h",
                         n, s.pc, got.taken, got.target, got.next_pc, exp.taken, exp.target, exp.next_pc);
            end
            if (s.uv) begin
                ui = s.upc[6:2];
`ifdef BP_GSHARE_EN
                upi = ui ^ m_ghr;
`else
                upi = ui;
`endif
                if (s.ut) begin
                    m_valid[ui] = 1; m_tag[ui] = s.upc[31:7]; m_tgt[ui] = s.utgt; m_jump[ui] = !s.ub;
                end
                if (s.ub) begin
                    if (s.ut && m_ctr[upi] != 2'b11) m_ctr[upi] = m_ctr[upi] + 2'd1;
                    if (!s.ut && m_ctr[upi] != 2'b00) m_ctr[upi] = m_ctr[upi] - 2'd1;
                    m_ghr = {m_ghr[3:0], s.ut};
                end
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef BP_GSHARE_EN
        test_gshare();
`else
        test_branch_train();
        test_saturation();
        test_jump_alias();
        test_same_cycle();
`endif
        test_random();
        @(posedge clk);
        #1;
        upd_valid = 0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
